// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the parallel-in/serial-out serializer.
// Holds the FSM state encoding and the default word width so that the
// serializer and the downstream detector bench agree on both.
package piso_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,   // no word held
        SHIFT = 1'b1    // word being transmitted
    } state_t;

endpackage

// File: rtl/piso_ser.sv
// piso_ser -- parallel-in/serial-out serializer with a valid/ready load port.
// Words are shifted out MSB first. When the last bit is on the line and
// Enable is high, a new word can be loaded on the same edge, which gives a
// gapless back-to-back stream.
//
// Ports:
//   CP          clock, rising edge
//   CR          asynchronous active-high reset
//   Din         parallel word (W bits, bit W-1 sent first)
//   Load_valid  Din holds a word to send
//   Load_ready  Din is taken on this edge if Load_valid is high
//   Enable      shift advance; low stalls the stream
//   Sout        serial bit (IDLE_LEVEL when nothing is valid)
//   Sout_valid  Sout carries a valid bit this cycle
//   Frame_end   Sout carries the LSB of the current word this cycle
module piso_ser
    import piso_pkg::*;
#(
    parameter int   W          = W_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         CP,
    input  logic         CR,
    input  logic [W-1:0] Din,
    input  logic         Load_valid,
    output logic         Load_ready,
    input  logic         Enable,
    output logic         Sout,
    output logic         Sout_valid,
    output logic         Frame_end
);

    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    state_t         state, state_n;
    logic [W-1:0]   sreg, sreg_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           last;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and outputs. Sout depends only on state and sreg, so it
    // has no path from any input; valid/ready/frame follow Enable directly.
    always_comb begin
        last       = (cnt == '0);
        state_n    = state;
        sreg_n     = sreg;
        cnt_n      = cnt;
        Load_ready = 1'b1;
        Sout       = IDLE_LEVEL;
        Sout_valid = 1'b0;
        Frame_end  = 1'b0;

        case (state)
            IDLE: begin
                if (Load_valid) begin
                    sreg_n  = Din;
                    cnt_n   = CNT_TOP;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                Sout       = sreg[W-1];
                Sout_valid = Enable;
                Frame_end  = Enable & last;
                Load_ready = Enable & last;
                if (Enable) begin
                    if (!last) begin
                        sreg_n = {sreg[W-2:0], 1'b0};
                        cnt_n  = cnt - CW'(1);
                    end else if (Load_valid) begin
                        // last bit leaving while the next word arrives
                        sreg_n = Din;
                        cnt_n  = CNT_TOP;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_ser.sv
// tb_piso_ser -- scoreboard bench for piso_ser (W=8, IDLE_LEVEL=0).
// The driver pushes the expected MSB-first bits of every accepted word into
// a queue; a monitor pops one entry per valid output cycle and compares.
module tb_piso_ser;

    logic       CP = 1'b0;
    logic       CR;
    logic [7:0] Din;
    logic       Load_valid;
    logic       Load_ready;
    logic       Enable;
    logic       Sout;
    logic       Sout_valid;
    logic       Frame_end;

    int pass_cnt = 0;
    int total    = 0;
    int run_len  = 0;
    int max_run  = 0;

    logic [1:0] exp_q[$];   // {bit, frame_end}

    piso_ser #(.W(8), .IDLE_LEVEL(1'b0)) dut (
        .CP(CP), .CR(CR), .Din(Din), .Load_valid(Load_valid),
        .Load_ready(Load_ready), .Enable(Enable), .Sout(Sout),
        .Sout_valid(Sout_valid), .Frame_end(Frame_end)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge CP);
            if (Sout_valid === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sout", int'(Sout), int'(e[1]));
                    check("frame_end", int'(Frame_end), int'(e[0]));
                end
            end else begin
                run_len = 0;
                check("frame_end_idle", int'(Frame_end), 0);
            end
        end
    end

    // Offer a word and hold it until the handshake; waits = number of
    // falling-edge samples where Load_ready was low.
    task automatic send(input logic [7:0] w, output int waits);
        Din        = w;
        Load_valid = 1'b1;
        waits      = 0;
        forever begin
            @(negedge CP);
            if (Load_ready) break;
            waits++;
            if (waits > 100) begin
                check("handshake_timeout", 0, 1);
                break;
            end
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back({w[i], i == 0});
        @(posedge CP); #1;
        Load_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge CP); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge CP);
        #1;
    endtask

    initial begin
        int waits;
        int c;
        CR = 1'b1; Din = '0; Load_valid = 1'b0; Enable = 1'b1;
        #1;
        check("rst_sout", int'(Sout), 0);
        check("rst_valid", int'(Sout_valid), 0);
        check("rst_frame", int'(Frame_end), 0);
        check("rst_ready", int'(Load_ready), 1);
        @(posedge CP); #1;
        CR = 1'b0;
        @(posedge CP); #1;

        // Single word 0x55, then idle in cycle 9.
        send(8'h55, waits);
        check("single_wait", waits, 0);
        repeat (8) @(posedge CP);
        #1;
        @(negedge CP);
        check("c9_ready", int'(Load_ready), 1);
        check("c9_valid", int'(Sout_valid), 0);
        check("c9_sout", int'(Sout), 0);
        check("single_left", exp_q.size(), 0);
        drain();

        // Back-to-back 0xA5, 0x3C: second handshake in cycle 8, no gap.
        max_run = 0;
        send(8'hA5, waits);
        send(8'h3C, waits);
        check("b2b_wait", waits, 7);
        drain();
        check("b2b_run", max_run, 16);

        // Stall in cycles 3..5 of 0xF0.
        send(8'hF0, waits);
        @(posedge CP); #1;
        @(posedge CP); #1;
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CP);
            check("stall_sout", int'(Sout), 1);
            check("stall_valid", int'(Sout_valid), 0);
            check("stall_ready", int'(Load_ready), 0);
            @(posedge CP); #1;
        end
        Enable = 1'b1;
        c = 6;
        forever begin
            @(negedge CP);
            if (Frame_end === 1'b1) break;
            c++;
            if (c > 40) break;
        end
        check("stall_frame_cycle", c, 11);
        drain();

        // Busy load: 0xFF offered in cycle 4 of 0x00, taken in cycle 8.
        max_run = 0;
        send(8'h00, waits);
        repeat (3) @(posedge CP);
        #1;
        send(8'hFF, waits);
        check("busy_wait", waits, 4);
        drain();
        check("busy_run", max_run, 16);

        // Reset in cycle 4 of 0x0F, then 0x5A from its MSB.
        send(8'h0F, waits);
        repeat (3) @(posedge CP);
        #1;
        CR = 1'b1;
        #1;
        check("mid_rst_valid", int'(Sout_valid), 0);
        check("mid_rst_ready", int'(Load_ready), 1);
        check("mid_rst_sout", int'(Sout), 0);
        check("abandoned_bits", exp_q.size(), 5);
        exp_q.delete();
        @(posedge CP); #1;
        CR = 1'b0;
        repeat (3) begin
            @(negedge CP);
            check("post_rst_idle", int'(Sout_valid), 0);
        end
        @(posedge CP); #1;
        send(8'h5A, waits);
        check("post_rst_wait", waits, 0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 Parameter W, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: value driven on Sout when no bit is valid.
REQ-003 CP  input  1  clock; all state updates on the rising edge.
REQ-004 CR  input  1  reset; asynchronous, active-high.
REQ-005 Din  input  W  parallel word; bit W-1 is transmitted first.
REQ-006 Load_valid  input  1  Din holds a word to be transmitted.
REQ-007 Load_ready  output  1  block accepts Din on this edge if Load_valid=1.
REQ-008 Enable  input  1  shift advance; 0 stalls the serial stream.
REQ-009 Sout  output  1  serial bit stream, intended as the Sin input of the downstream sequence detector.
REQ-010 Sout_valid  output  1  Sout carries a valid bit this cycle.
REQ-011 Frame_end  output  1  Sout carries the last bit (LSB) of the current word this cycle.

Function
REQ-012 The state machine SHALL have two states: IDLE (no word held) and SHIFT (word being transmitted); a bit counter cnt of width clog2(W) tracks the remaining bits.
REQ-013 A handshake SHALL occur on a rising CP edge where Load_valid=1 and Load_ready=1; only then is Din sampled into the shift register.
REQ-014 In IDLE, Load_ready SHALL be 1, Sout SHALL be IDLE_LEVEL, and Sout_valid and Frame_end SHALL be 0.
REQ-015 A handshake in IDLE SHALL load Din, set cnt=W-1, and move to SHIFT.
REQ-016 In SHIFT, Sout SHALL equal the shift-register MSB, driven directly from a register, with no combinational path from any input.
REQ-017 In SHIFT, Sout_valid SHALL equal Enable; Frame_end SHALL equal Enable AND (cnt==0).
REQ-018 In SHIFT with Enable=1 and cnt!=0, the register SHALL shift left by one and cnt SHALL decrement on the edge.
REQ-019 In SHIFT with Enable=0, the shift register, cnt, and state SHALL hold unchanged.
REQ-020 In SHIFT, Load_ready SHALL be 1 only when Enable=1 and cnt==0; otherwise it SHALL be 0.
REQ-021 At cnt==0 with Enable=1: if a handshake occurs, the block SHALL load the new word, set cnt=W-1, and stay in SHIFT (gapless back-to-back); if no handshake occurs, it SHALL return to IDLE.
REQ-022 Latency: for a handshake at edge k with Enable held at 1, the MSB SHALL appear in cycle k+1 and the LSB in cycle k+W.
REQ-023 Load_valid asserted while Load_ready=0 SHALL be ignored; the upstream source holds Din and Load_valid until a handshake occurs.

Reset
REQ-024 While CR=1, the block SHALL force state=IDLE, cnt=0, shift register=0, Sout=IDLE_LEVEL, Sout_valid=0, Frame_end=0, and Load_ready=1.
REQ-025 Reset asserted during SHIFT SHALL abandon the current word with no further bits emitted; after release, the block SHALL behave as freshly reset.

Structure
REQ-026 The state encodings (IDLE=1'b0, SHIFT=1'b1) and the default W SHALL be defined in the shared package piso_pkg for reuse by the detector testbench.
REQ-027 The block SHALL be a single module with one sequential process and one combinational next-state/output process; no sub-module is required.

Verification
REQ-028 Reset: CR=1 asynchronously mid-cycle -> Sout=0, Sout_valid=0, Load_ready=1 immediately, without waiting for a CP edge.
REQ-029 Single word: Din=8'h55, Enable=1, one handshake -> Sout=0,1,0,1,0,1,0,1 in cycles 1..8; Frame_end=1 only in cycle 8; IDLE in cycle 9.
REQ-030 Back-to-back: 8'hA5 then 8'h3C with Load_valid held -> 16 consecutive valid bits 1010_0101_0011_1100; second handshake in cycle 8; no gap.
REQ-031 Stall: Din=8'hF0, Enable=0 in cycles 3..5 -> Sout holds 1 and Sout_valid=0 in cycles 3..5; remaining bits resume unchanged; Frame_end=1 in cycle 11.
REQ-032 Busy load: Load_valid=1 with Din=8'hFF during cycle 4 of word 8'h00 -> not accepted; accepted at cycle 8; 8 zeros then 8 ones.
REQ-033 Reset mid-word: CR pulse in cycle 4 of 8'h0F -> stream stops; next word 8'h5A then transmits correctly from its MSB.
